btn_debounce: RTL

//   Conditions the raw push-button inputs (btn_north/east/south/west) of the 50 MHz

---
 rtl/btn_debounce.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, per-channel debounce FSM, level and strobes.
// Optional auto-repeat strobes are compiled in with `define BTN_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_LO, S_PHI, S_HI, S_PLO} state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          level_hi;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_LO;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // counter is cleared on every transition so it never wraps
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        S_LO: begin
          if (sync2[i]) begin
            state_nxt = S_PHI;
            cnt_nxt   = '0;
          end
        end
        S_PHI: begin
          if (!sync2[i]) begin
            state_nxt = S_LO;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = S_HI;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_HI: begin
          if (!sync2[i]) begin
            state_nxt = S_PLO;
            cnt_nxt   = '0;
          end
        end
        S_PLO: begin
          if (sync2[i]) begin
            state_nxt = S_HI;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = S_LO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign level_hi = (state == S_HI) || (state == S_PLO);

    // strobes are edges of the registered level, so rise and fall are mutually exclusive
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        level_q <= level_hi;
        rise_q  <= level_hi & ~level_q;
        fall_q  <= ~level_hi & level_q;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rcnt;
    logic          rep_q;

    // down-counter frozen in S_PLO so a short release bounce resumes the cadence
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (state == S_PHI && state_nxt == S_HI) begin
          rcnt <= RW'(REPEAT_DELAY);
        end else if (state == S_HI) begin
          if (rcnt == '0) begin
            rep_q <= 1'b1;
            rcnt  <= RW'(REPEAT_RATE - 1);
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end else if (state == S_LO) begin
          rcnt <= '0;
        end
      end
    end

    assign btn_repeat[i] = rep_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

endmodule
